// File: rtl/debug_dump_tx.sv
// Debug dump serializer: snapshots PC, register file and pipeline latches on request,
// then streams HEADER, little-endian byte-padded payload and an XOR checksum into the UART TX FIFO.
module debug_dump_tx #(
    parameter int          SIZE          = 32,
    parameter int          NUM_REGISTERS = 32,
    parameter int          IF_ID_SIZE    = 64,
    parameter int          ID_EX_SIZE    = 129,
    parameter int          EX_MEM_SIZE   = 78,
    parameter int          MEM_WB_SIZE   = 72,
    parameter logic [7:0]  HEADER        = 8'hA5
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    input  logic [SIZE-1:0]                 i_pc,
    input  logic [NUM_REGISTERS*SIZE-1:0]   i_registers_debug,
    input  logic [IF_ID_SIZE-1:0]           i_IF_ID,
    input  logic [ID_EX_SIZE-1:0]           i_ID_EX,
    input  logic [EX_MEM_SIZE-1:0]          i_EX_MEM,
    input  logic [MEM_WB_SIZE-1:0]          i_MEM_WB,
    input  logic                            i_tx_full,
    output logic [7:0]                      o_tx_data,
    output logic                            o_tx_start,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int REG_B     = (SIZE + 7) / 8;
    localparam int IFID_B    = (IF_ID_SIZE + 7) / 8;
    localparam int IDEX_B    = (ID_EX_SIZE + 7) / 8;
    localparam int EXMEM_B   = (EX_MEM_SIZE + 7) / 8;
    localparam int MEMWB_B   = (MEM_WB_SIZE + 7) / 8;
    localparam int REG_OFF   = REG_B;
    localparam int IFID_OFF  = REG_OFF + NUM_REGISTERS * REG_B;
    localparam int IDEX_OFF  = IFID_OFF + IFID_B;
    localparam int EXMEM_OFF = IDEX_OFF + IDEX_B;
    localparam int MEMWB_OFF = EXMEM_OFF + EXMEM_B;
    localparam int PAY_B     = MEMWB_OFF + MEMWB_B;
    localparam int SNAP_W    = PAY_B * 8;
    localparam int IDX_W     = $clog2(PAY_B + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAY_B - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PAYLOAD,
        S_CHECKSUM,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [SNAP_W-1:0]  snap_d;
    logic [SNAP_W-1:0]  snap_q;
    logic [7:0]         data_q;
    logic [7:0]         csum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               busy_q;
    logic               done_q;
    logic               push;

    // Byte-aligned image of the inputs; each field starts on a byte boundary with zero padding above it.
    always_comb begin
        snap_d = '0;
        snap_d[0 +: SIZE] = i_pc;
        for (int k = 0; k < NUM_REGISTERS; k++) begin
            snap_d[(REG_OFF + k * REG_B) * 8 +: SIZE] = i_registers_debug[k * SIZE +: SIZE];
        end
        snap_d[IFID_OFF * 8 +: IF_ID_SIZE]   = i_IF_ID;
        snap_d[IDEX_OFF * 8 +: ID_EX_SIZE]   = i_ID_EX;
        snap_d[EXMEM_OFF * 8 +: EX_MEM_SIZE] = i_EX_MEM;
        snap_d[MEMWB_OFF * 8 +: MEM_WB_SIZE] = i_MEM_WB;
    end

    assign push = ((state_q == S_HEADER) || (state_q == S_PAYLOAD) || (state_q == S_CHECKSUM))
                  && !i_tx_full;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            csum_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        snap_q  <= snap_d;
                        data_q  <= HEADER;
                        csum_q  <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (push) begin
                        data_q  <= snap_q[7:0];
                        snap_q  <= snap_q >> 8;
                        state_q <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    // data_q always holds the byte currently offered; the snapshot shifts one byte per accept.
                    if (push) begin
                        csum_q <= csum_q ^ data_q;
                        idx_q  <= idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            data_q  <= csum_q ^ data_q;
                            state_q <= S_CHECKSUM;
                        end else begin
                            data_q <= snap_q[7:0];
                            snap_q <= snap_q >> 8;
                        end
                    end
                end
                S_CHECKSUM: begin
                    if (push) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_tx_start = push;
    assign o_tx_data  = data_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_debug_dump_tx.sv
// Bench for debug_dump_tx: a frame-level model builds the expected byte stream from the
// inputs present at start; a negedge process checks every output cycle against it.
module tb_debug_dump_tx;

    logic          clk = 1'b0;
    logic          rst, start, full;
    logic [31:0]   pc;
    logic [1023:0] regs;
    logic [63:0]   ifid;
    logic [128:0]  idex;
    logic [77:0]   exmem;
    logic [71:0]   memwb;
    logic [7:0]    tx_data;
    logic          tx_start, busy, done;

    always #5 clk = ~clk;

    debug_dump_tx dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_start           (start),
        .i_pc              (pc),
        .i_registers_debug (regs),
        .i_IF_ID           (ifid),
        .i_ID_EX           (idex),
        .i_EX_MEM          (exmem),
        .i_MEM_WB          (memwb),
        .i_tx_full         (full),
        .o_tx_data         (tx_data),
        .o_tx_start        (tx_start),
        .o_busy            (busy),
        .o_done            (done)
    );

    int          passed = 0;
    int          total  = 0;
    int          cyc    = 0;
    int          c0     = 0;
    int          done_cyc = 0;
    int          exp_pos = 0;
    int          m_tail  = 0;
    bit          m_active = 1'b0;
    bit          chk_en   = 1'b0;
    bit          skip_one = 1'b0;
    logic [7:0]  xacc;
    logic [7:0]  exp_frame[$];
    logic [7:0]  cap[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_field(input logic [255:0] v, input int bits);
        logic [7:0] b;
        for (int i = 0; i < (bits + 7) / 8; i++) begin
            b = v[8*i +: 8];
            exp_frame.push_back(b);
            xacc ^= b;
        end
    endtask

    // Frame = header, fields in order (little-endian, byte-padded), XOR of payload.
    task automatic build_expected();
        exp_frame.delete();
        xacc = 8'h00;
        exp_frame.push_back(8'hA5);
        add_field(256'(pc), 32);
        for (int k = 0; k < 32; k++) add_field(256'(regs[k*32 +: 32]), 32);
        add_field(256'(ifid), 64);
        add_field(256'(idex), 129);
        add_field(256'(exmem), 78);
        add_field(256'(memwb), 72);
        exp_frame.push_back(xacc);
    endtask

    task automatic clear_inputs();
        pc = '0; regs = '0; ifid = '0; idex = '0; exmem = '0; memwb = '0;
    endtask

    task automatic scramble_inputs();
        pc = $urandom;
        for (int i = 0; i < 32; i++) regs[i*32 +: 32] = $urandom;
        for (int i = 0; i < 64; i++)  ifid[i]  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 129; i++) idex[i]  = 1'($urandom_range(0, 1));
        for (int i = 0; i < 78; i++)  exmem[i] = 1'($urandom_range(0, 1));
        for (int i = 0; i < 72; i++)  memwb[i] = 1'($urandom_range(0, 1));
    endtask

    always @(negedge clk) begin
        bit es;
        if (chk_en && !skip_one) begin
            es = m_active && (exp_pos < exp_frame.size()) && !full;
            chk("tx_start", 32'(tx_start), 32'(es));
            if (m_active && exp_pos < exp_frame.size()) begin
                chk("tx_data", 32'(tx_data), 32'(exp_frame[exp_pos]));
                chk("busy_in_frame", 32'(busy), 32'd1);
                chk("done_in_frame", 32'(done), 32'd0);
                if (es) begin
                    cap.push_back(tx_data);
                    exp_pos++;
                    if (exp_pos == exp_frame.size()) m_tail = 1;
                end
            end else if (m_active && m_tail == 1) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_at_done", 32'(busy), 32'd1);
                done_cyc = cyc - c0 + 1;
                m_tail = 2;
            end else if (m_active && m_tail == 2) begin
                chk("done_after", 32'(done), 32'd0);
                chk("busy_drop", 32'(busy), 32'd0);
                m_active = 1'b0;
                m_tail = 0;
            end else begin
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
            end
        end
    end

    task automatic run_frame(input int stall_at, input int stall_len, input int mid_start_at,
                             input int abort_at, input bit scramble);
        int n;
        bit stalled;
        build_expected();
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc; exp_pos = 0; m_tail = 0; done_cyc = 0;
        cap.delete();
        m_active = 1'b1;
        if (scramble) scramble_inputs();
        stalled = 1'b0;
        n = 0;
        while (m_active && n < 500) begin
            if (abort_at >= 0 && exp_pos == abort_at) begin
                rst = 1'b1; skip_one = 1'b1; m_active = 1'b0;
                tick();
                rst = 1'b0; skip_one = 1'b0;
                break;
            end
            if (!stalled && stall_at >= 0 && exp_pos == stall_at) begin
                full = 1'b1;
                repeat (stall_len) tick();
                full = 1'b0;
                stalled = 1'b1;
                continue;
            end
            start = (mid_start_at >= 0 && exp_pos == mid_start_at);
            tick();
            n++;
        end
        start = 1'b0;
        chk("frame_timeout", 32'(m_active), 32'd0);
        m_active = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b1; full = 1'b0;
        clear_inputs();
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();

        // Basic frame
        clear_inputs();
        pc = 32'h0000_0010;
        run_frame(-1, 0, -1, -1, 1'b0);
        chk("basic_len", 32'(cap.size()), 32'd178);
        chk("basic_hdr", 32'(cap[0]), 32'hA5);
        chk("basic_pc0", 32'(cap[1]), 32'h10);
        chk("basic_pc1", 32'(cap[2]), 32'h00);
        chk("basic_csum", 32'(cap[177]), 32'h10);
        chk("basic_done_cycle", 32'(done_cyc), 32'd179);
        repeat (2) tick();

        // Register order
        clear_inputs();
        for (int k = 0; k < 32; k++) regs[k*32 +: 32] = 32'(k);
        run_frame(-1, 0, -1, -1, 1'b0);
        chk("reg_len", 32'(cap.size()), 32'd178);
        for (int k = 0; k < 32; k++) chk("reg_byte", 32'(cap[1 + 4 + 4*k]), 32'(k));
        chk("reg_upper", 32'(cap[1 + 4 + 4*5 + 1]), 32'h00);
        chk("reg_csum", 32'(cap[177]), 32'h00);
        repeat (2) tick();

        // Padding of ID_EX
        clear_inputs();
        idex = '1;
        run_frame(-1, 0, -1, -1, 1'b0);
        for (int i = 0; i < 16; i++) chk("idex_ff", 32'(cap[1 + 140 + i]), 32'hFF);
        chk("idex_top", 32'(cap[1 + 156]), 32'h01);
        chk("idex_csum", 32'(cap[177]), 32'h01);
        repeat (2) tick();

        // Backpressure, input change after start, ignored start
        scramble_inputs();
        run_frame(21, 5, 60, -1, 1'b1);
        chk("stall_len", 32'(cap.size()), 32'd178);
        chk("stall_done_cycle", 32'(done_cyc), 32'd184);
        repeat (2) tick();

        // Abort at payload byte 50, then a clean frame
        scramble_inputs();
        run_frame(-1, 0, -1, 51, 1'b0);
        chk("abort_pushed", 32'(cap.size()), 32'd51);
        tick();
        chk("abort_tx_data", 32'(tx_data), 32'd0);
        chk("abort_tx_start", 32'(tx_start), 32'd0);
        repeat (3) tick();
        clear_inputs();
        pc = 32'h0000_0010;
        run_frame(-1, 0, -1, -1, 1'b0);
        chk("restart_len", 32'(cap.size()), 32'd178);
        chk("restart_hdr", 32'(cap[0]), 32'hA5);
        chk("restart_csum", 32'(cap[177]), 32'h10);
        repeat (2) tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/debug_dump_tx.md
# debug_dump_tx

Debug-side serializer that answers a dump request by snapshotting the processor state (PC, register file, all four pipeline latches) in a single cycle, then streaming it as a framed byte sequence into the UART transmit FIFO. It is the transmit end of the debug UART link: the receive path loads programs and issues commands, and this block returns processor state to the host. It sits between the debugger command logic and the UART TX FIFO.

## Interface
- SIZE, 32, data word width
- NUM_REGISTERS, 32, register file entries
- IF_ID_SIZE, 64, IF/ID latch width
- ID_EX_SIZE, 129, ID/EX latch width
- EX_MEM_SIZE, 78, EX/MEM latch width
- MEM_WB_SIZE, 72, MEM/WB latch width
- HEADER, 8'hA5, frame start byte

- i_clk  in  1  clock; single clock domain
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  dump request; sampled only in IDLE
- i_pc  in  SIZE  program counter
- i_registers_debug  in  NUM_REGISTERS*SIZE  register file, reg k at bits [k*SIZE +: SIZE]
- i_IF_ID / i_ID_EX / i_EX_MEM / i_MEM_WB  in  *_SIZE  pipeline latch contents
- i_tx_full  in  1  TX FIFO full; no push allowed while high
- o_tx_data  out  8  byte presented to FIFO
- o_tx_start  out  1  FIFO push strobe
- o_busy  out  1  high from the cycle after start accept until return to IDLE
- o_done  out  1  one-cycle pulse after the last byte is accepted

## Operation
- States: IDLE, HEADER, PAYLOAD, CHECKSUM, DONE.
- IDLE: when i_start=1, capture the snapshot at that edge and go to HEADER. i_start in any other state is ignored.
- Snapshot: a private register holding, in order, PC, reg0..reg(N-1), IF_ID, ID_EX, EX_MEM, MEM_WB. Each field is zero-padded up to whole bytes (ceil(bits/8)). Inputs are not looked at again until the next request.
- Byte order: fields in the order above; each field is sent little-endian (bits [7:0] first). Default byte counts: PC 4, regs 128, IF_ID 8, ID_EX 17 (top byte = {7'b0, bit128}), EX_MEM 10, MEM_WB 9. Payload total is 176.
- Frame: HEADER byte, then payload bytes, then the checksum byte. Checksum = XOR of all payload bytes (the header is excluded). Default frame length is 178 bytes.
- Byte counter: PAYLOAD advances the byte index once per accepted byte and moves to CHECKSUM after the last index. The counter is wide enough for the payload length and never wraps within a frame.
- Running XOR: reset to 0 on entering HEADER. The byte shown in CHECKSUM is the accumulator after the final payload byte.
- DONE: assert o_done for one cycle, then go to IDLE.

## Timing
- o_tx_data is driven from registered state only and is stable for as long as a byte is pending.
- o_tx_start = (state in HEADER/PAYLOAD/CHECKSUM) & ~i_tx_full, combinational. A byte is accepted on the rising edge where o_tx_start=1.
- Each byte is pushed exactly once. At most one push per cycle.
- While i_tx_full=1, state, index, data and checksum all hold.
- Latency with no backpressure: start accepted at edge 0. Header is pushed in cycle 1, payload in cycles 2–177, checksum in cycle 178. o_done=1 in cycle 179. o_busy drops in cycle 180, and the block is IDLE and able to accept a new start from cycle 180.
- Reset values: state IDLE, o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0, counter 0, checksum 0.
- Reset mid-frame: on the reset edge, return to IDLE with no further pushes. The partial frame is abandoned and the host resynchronizes on HEADER.
- If i_rst and i_start are high in the same cycle, reset wins.

## Test plan
- **Reset:** assert i_rst with i_start=1 -> all outputs 0, no push, o_busy=0.
- **Basic frame:** PC=32'h00000010, all other inputs 0, i_tx_full=0, start pulse ->
  - 178 pushes in consecutive cycles 1–178;
  - bytes: A5, 10, 00, 00, 00, …zeros…, checksum 0x10;
  - o_done in cycle 179.
- **Register order:** reg k = 32'h0000_00kk (k=0..31), all else 0 -> payload bytes 4+4k = k, other register bytes 0, checksum = XOR of 0..31 = 0x00.
- **Padding:** i_ID_EX all ones -> the ID_EX field (payload bytes 140–156) is 16×FF followed by 0x01.
- **Backpressure and snapshot:**
  - hold i_tx_full=1 for 5 cycles during payload byte 20 -> no o_tx_start, o_tx_data held, stream identical to the unstalled case, o_done 5 cycles later;
  - change all inputs after start -> frame still carries the start-cycle values.
- **Abort and ignored start:**
  - i_start asserted during PAYLOAD -> ignored, frame unaffected;
  - i_rst at byte 50 -> no push from the next cycle on, IDLE;
  - a new start then produces a full 178-byte frame beginning with A5.
